// File: rtl/directory_tag_lookup_if.sv
// Bundle between the directory controller, directory_tag_store and the
// compare/allocate stage. The lookup stage is the slave side.
interface directory_tag_lookup_if #(
  parameter int unsigned TAG_SIZE = 18,
  parameter int unsigned IW       = 9
);
  // Request, shared with the store
  logic [2:0]            operation;
  logic [IW-1:0]         idx;
  logic [TAG_SIZE-1:0]   tag_in_rd;
  // Store read data (tag_lines_out of the store)
  logic [TAG_SIZE*8-1:0] tag_lines_in;
  // Store writeback port
  logic [TAG_SIZE*8-1:0] tag_out_wb;
  logic [IW-1:0]         idx_out_wb;
  logic                  alloc;
  logic                  st_fwd;
  // Response to the controller
  logic                  resp_valid;
  logic                  resp_hit;
  logic [2:0]            resp_way;
  logic                  evict_valid;
  logic [TAG_SIZE-1:0]   evict_tag;

  modport master (
    output operation, idx, tag_in_rd, tag_lines_in,
    input  tag_out_wb, idx_out_wb, alloc, st_fwd,
    input  resp_valid, resp_hit, resp_way, evict_valid, evict_tag
  );

  modport slave (
    input  operation, idx, tag_in_rd, tag_lines_in,
    output tag_out_wb, idx_out_wb, alloc, st_fwd,
    output resp_valid, resp_hit, resp_way, evict_valid, evict_tag
  );
endinterface

// File: rtl/directory_tag_lookup.sv
// Compare/allocate stage behind directory_tag_store. A request is registered
// while the store reads its 8-way line; the next cycle the line is compared,
// a hit or victim way is chosen, the store writeback is driven, and a
// registered hit/evict response follows one cycle later.
module directory_tag_lookup #(
  parameter int unsigned TAG_SIZE = 18,
  parameter int unsigned IDX_CNT  = 512,
  localparam int unsigned IW      = $clog2(IDX_CNT)
) (
  input logic                   clk,
  input logic                   rst,
  directory_tag_lookup_if.slave bus
);

  localparam logic [2:0] OpLookup      = 3'd1;
  localparam logic [2:0] OpLookupAlloc = 3'd2;
  localparam logic [2:0] OpInval       = 3'd3;

  // Tree-PLRU: b0 root, b1/b2 halves, b3..b6 pairs; a 0 bit means victim left
  function automatic logic [6:0] plru_touch(input logic [6:0] p, input logic [2:0] w);
    logic [6:0] t;
    t    = p;
    t[0] = ~w[2];
    if (w[2]) t[2] = ~w[1];
    else      t[1] = ~w[1];
    case (w[2:1])
      2'd0:    t[3] = ~w[0];
      2'd1:    t[4] = ~w[0];
      2'd2:    t[5] = ~w[0];
      default: t[6] = ~w[0];
    endcase
    return t;
  endfunction

  function automatic logic [2:0] plru_victim(input logic [6:0] p);
    logic [2:0] v;
    v[2] = p[0];
    v[1] = p[0] ? p[2] : p[1];
    v[0] = p[0] ? (p[2] ? p[6] : p[5]) : (p[1] ? p[4] : p[3]);
    return v;
  endfunction

  // S1 request register
  logic                s1_vld;
  logic [2:0]          s1_op;
  logic [IW-1:0]       s1_idx;
  logic [TAG_SIZE-1:0] s1_tag;

  // Per-set state
  logic [7:0] valid_q [IDX_CNT];
  logic [6:0] plru_q  [IDX_CNT];

  // S1 combinational results
  logic [7:0]            cur_valid;
  logic [6:0]            cur_plru;
  logic [7:0]            match;
  logic                  hit;
  logic [2:0]            hit_way;
  logic [2:0]            inv_way;
  logic [2:0]            victim;
  logic                  alloc;
  logic [TAG_SIZE*8-1:0] wb_line;
  logic [TAG_SIZE-1:0]   old_tag;
  logic [7:0]            valid_d;
  logic [6:0]            plru_d;

  // Registered response
  logic                resp_valid_q;
  logic                resp_hit_q;
  logic [2:0]          resp_way_q;
  logic                evict_valid_q;
  logic [TAG_SIZE-1:0] evict_tag_q;

  // Register the S0 request; only ops 1..3 carry a valid request
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_op  <= '0;
      s1_idx <= '0;
      s1_tag <= '0;
    end else begin
      s1_vld <= (bus.operation == OpLookup) || (bus.operation == OpLookupAlloc) ||
                (bus.operation == OpInval);
      s1_op  <= bus.operation;
      s1_idx <= bus.idx;
      s1_tag <= bus.tag_in_rd;
    end
  end

  // Compare, victim selection, writeback line and next per-set state
  always_comb begin
    cur_valid = valid_q[s1_idx];
    cur_plru  = plru_q[s1_idx];
    match     = '0;
    hit_way   = '0;
    inv_way   = '0;
    for (int unsigned w = 0; w < 8; w++) begin
      match[w] = cur_valid[w] && (bus.tag_lines_in[w*TAG_SIZE +: TAG_SIZE] == s1_tag);
    end
    // Downward scan so the lowest matching / invalid way wins
    for (int w = 7; w >= 0; w--) begin
      if (match[w])      hit_way = 3'(w);
      if (!cur_valid[w]) inv_way = 3'(w);
    end
    hit    = |match;
    victim = (&cur_valid) ? plru_victim(cur_plru) : inv_way;
    // Reset drops the request sitting in S1, including its store write
    alloc  = s1_vld && !rst && (s1_op == OpLookupAlloc) && !hit;

    wb_line = bus.tag_lines_in;
    old_tag = '0;
    for (int unsigned w = 0; w < 8; w++) begin
      if (3'(w) == victim) begin
        wb_line[w*TAG_SIZE +: TAG_SIZE] = s1_tag;
        old_tag = bus.tag_lines_in[w*TAG_SIZE +: TAG_SIZE];
      end
    end

    valid_d = cur_valid;
    plru_d  = cur_plru;
    if (s1_op == OpInval) begin
      if (hit) valid_d[hit_way] = 1'b0;
    end else if (hit) begin
      plru_d = plru_touch(cur_plru, hit_way);
    end else if (alloc) begin
      valid_d[victim] = 1'b1;
      plru_d          = plru_touch(cur_plru, victim);
    end
  end

  // Per-set valid/PLRU update at the end of S1
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < IDX_CNT; i++) begin
        valid_q[i] <= '0;
        plru_q[i]  <= '0;
      end
    end else if (s1_vld) begin
      valid_q[s1_idx] <= valid_d;
      plru_q[s1_idx]  <= plru_d;
    end
  end

  // Response register, presented two cycles after S0
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_way_q    <= '0;
      evict_valid_q <= 1'b0;
      evict_tag_q   <= '0;
    end else begin
      resp_valid_q  <= s1_vld;
      resp_hit_q    <= s1_vld && hit;
      resp_way_q    <= !s1_vld ? 3'd0 : hit ? hit_way : alloc ? victim : 3'd0;
      evict_valid_q <= alloc && cur_valid[victim];
      evict_tag_q   <= (alloc && cur_valid[victim]) ? old_tag : '0;
    end
  end

  assign bus.tag_out_wb  = wb_line;
  assign bus.idx_out_wb  = s1_idx;
  assign bus.alloc       = alloc;
  // Same-set read in S0 must see the line being written this cycle
  assign bus.st_fwd      = alloc && (bus.operation != 3'd0) && (bus.idx == s1_idx);
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_hit    = resp_hit_q;
  assign bus.resp_way    = resp_way_q;
  assign bus.evict_valid = evict_valid_q;
  assign bus.evict_tag   = evict_tag_q;

endmodule
